regs_wb_arbiter: RTL and testbench
==================================

// Module: regs_wb_arbiter
// PURPOSE
//   Owns the single write port of the 32x32 register file (async read, sync write, x0 never written).
//   Arbitrates that port between two sources: pipeline writeback (src P) and the long-latency multi-cycle unit (src L, div/mem).
//   Keeps a pending-write scoreboard for L destinations and raises an ID-stage stall on RAW/WAW hazards.
//   Sits between wb_stage / the multi-cycle unit and regs; the regs write port is driven only from here.
// PARAMETERS
//   STARVE_MAX  4  consecutive cycles L may lose arbitration before it is forced to win (range 1..15)
// PORTS
//   clk              in   1   clock, all state updates on posedge
//   rst_n            in   1   asynchronous active-low reset
//   p_valid_i        in   1   pipeline writeback request
//   p_waddr_i        in   5   pipeline destination register
//   p_wdata_i        in   32  pipeline write data
//   p_ready_o        out  1   pipeline request accepted this cycle
//   l_valid_i        in   1   multi-cycle unit writeback request
//   l_waddr_i        in   5   multi-cycle unit destination register
//   l_wdata_i        in   32  multi-cycle unit write data
//   l_ready_o        out  1   L request accepted this cycle
//   l_issue_i        in   1   L operation issued this cycle; marks l_issue_rd_i pending
//   l_issue_rd_i     in   5   destination of the issued L operation
//   id_reg1_raddr_i  in   5   ID source 1
//   id_reg2_raddr_i  in   5   ID source 2
//   id_rd_i          in   5   ID destination
//   id_stall_o       out  1   ID must hold: a source or the destination is pending
//   wb_op_c_o        out  32  to regs write data
//   wb_reg_waddr_o   out  5   to regs write address
//   wb_reg_we_o      out  1   to regs write enable
// BEHAVIOUR
//   Reset (async, rst_n=0): wb_reg_we_o=0, wb_reg_waddr_o=0, wb_op_c_o=0, pending[31:0]=0, starve_cnt=0.
//     p_ready_o, l_ready_o and id_stall_o are combinational and read 0 while in reset.
//   Arbitration (combinational grant, at most one winner per cycle):
//     - only P valid -> P wins; only L valid -> L wins; neither -> no grant.
//     - both valid -> P wins unless starve_cnt==STARVE_MAX, in which case L wins.
//     - p_ready_o = grant to P; l_ready_o = grant to L. A loser holds valid/addr/data stable until granted.
//   starve_cnt: +1 when L valid and loses; cleared when L wins or L is not valid; saturates at STARVE_MAX.
//   Write port, registered with 1-cycle latency: on the edge after a grant,
//     wb_reg_we_o=1, waddr/data = the winner's. With no grant, we_o=0 and addr/data hold their last value.
//   x0: a granted write to address 0 completes the handshake (ready=1) but wb_reg_we_o stays 0.
//   Scoreboard:
//     - l_issue_i with rd!=0 sets pending[rd] on the next edge.
//     - a granted L write clears pending[l_waddr_i] on the same edge.
//     - issue and L-write clear on the same rd in the same cycle: set wins, so the bit stays 1.
//     - pending[0] is always 0.
//   id_stall_o = pending[raddr1] | pending[raddr2] | pending[id_rd_i], all combinational.
//     Hazard bypass: an L write granted this cycle does not suppress the stall. The stall drops on the
//     cycle after the clearing edge, which aligns with the regs write landing.
//   P writes never touch the scoreboard. Because ID stalls on WAW, P can never write a pending register.
//   Reset mid-operation: all pending bits and starve_cnt clear; any in-flight registered write is dropped (we_o=0).
// TESTING
//   1. Reset -> wb_reg_we_o=0, id_stall_o=0, both readies 0. Release, then P valid waddr=5 data=0xDEADBEEF
//      -> p_ready_o=1; next cycle we_o=1, waddr=5, data=0xDEADBEEF.
//   2. P and L both valid continuously, STARVE_MAX=4 -> P wins 4 cycles, L wins the 5th (l_ready_o=1),
//      starve_cnt returns to 0, then P wins again.
//   3. l_issue_i rd=7, then ID raddr1=7 -> id_stall_o=1 until L writes rd 7. Stall is still 1 in the grant
//      cycle and 0 the cycle after; regs shows we_o=1, waddr=7.
//   4. Same cycle: l_issue_i rd=9 and an L write to 9 granted -> pending[9] remains 1, id_stall_o=1 for raddr2=9.
//   5. P write to x0 data=0x1234 -> p_ready_o=1, wb_reg_we_o stays 0. l_issue_i rd=0 -> no stall ever.
//   6. Pending bits for 3,4 set and an L request waiting; assert rst_n=0 mid-stream -> pending clear,
//      we_o=0 immediately, id_stall_o=0 after release.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: sole owner of the register-file write port.
// Arbitrates pipeline (P) vs multi-cycle (L) writeback, tracks L hazards.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   p_valid_i/waddr/wdata      pipeline writeback request
//   p_ready_o                  pipeline request granted this cycle
//   l_valid_i/waddr/wdata      multi-cycle writeback request
//   l_ready_o                  L request granted this cycle
//   l_issue_i, l_issue_rd_i    L op issued; marks its rd pending
//   id_reg1/2_raddr_i, id_rd_i ID-stage register operands
//   id_stall_o                 ID hazard on a pending register
//   wb_op_c_o/reg_waddr/we     registered regs write port
module regs_wb_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p_valid_i,
   input  logic [4:0]  p_waddr_i,
   input  logic [31:0] p_wdata_i,
   output logic        p_ready_o,
   input  logic        l_valid_i,
   input  logic [4:0]  l_waddr_i,
   input  logic [31:0] l_wdata_i,
   output logic        l_ready_o,
   input  logic        l_issue_i,
   input  logic [4:0]  l_issue_rd_i,
   input  logic [4:0]  id_reg1_raddr_i,
   input  logic [4:0]  id_reg2_raddr_i,
   input  logic [4:0]  id_rd_i,
   output logic        id_stall_o,
   output logic [31:0] wb_op_c_o,
   output logic [4:0]  wb_reg_waddr_o,
   output logic        wb_reg_we_o
);

   localparam int CW = 4;
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_P,
      GNT_L
   } gnt_e;

   gnt_e          gnt;
   logic          starved;
   logic [CW-1:0] starve_cnt;
   logic [CW-1:0] starve_nxt;
   logic [31:0]   pending;
   logic [31:0]   pending_nxt;
   logic [4:0]    w_addr;
   logic [31:0]   w_data;
   logic          w_any;

   assign starved = (starve_cnt == SMAX);

   // Mutually exclusive grant terms: L only beats P once starved.
   always_comb begin
      gnt = GNT_NONE;
      unique case (1'b1)
         (p_valid_i && !(l_valid_i && starved)):
            gnt = GNT_P;
         (l_valid_i && (!p_valid_i || starved)):
            gnt = GNT_L;
         default:
            gnt = GNT_NONE;
      endcase
   end

   // Readies are forced low while reset is asserted.
   assign p_ready_o = rst_n && (gnt == GNT_P);
   assign l_ready_o = rst_n && (gnt == GNT_L);

   always_comb begin
      w_any  = 1'b0;
      w_addr = p_waddr_i;
      w_data = p_wdata_i;
      unique case (gnt)
         GNT_P: begin
            w_any  = 1'b1;
            w_addr = p_waddr_i;
            w_data = p_wdata_i;
         end
         GNT_L: begin
            w_any  = 1'b1;
            w_addr = l_waddr_i;
            w_data = l_wdata_i;
         end
         default: begin
            w_any  = 1'b0;
         end
      endcase
   end

   always_comb begin
      starve_nxt = '0;
      if (l_valid_i && (gnt != GNT_L)) begin
         if (starved) begin
            starve_nxt = starve_cnt;
         end else begin
            starve_nxt = starve_cnt + CW'(1);
         end
      end
   end

   // Clear first, then set: an issue to the same rd keeps it pending.
   always_comb begin
      pending_nxt = pending;
      if (gnt == GNT_L) begin
         pending_nxt[l_waddr_i] = 1'b0;
      end
      if (l_issue_i && (l_issue_rd_i != 5'd0)) begin
         pending_nxt[l_issue_rd_i] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Stall uses the registered scoreboard only, so it drops one
   // cycle after the clearing grant, together with the regs write.
   assign id_stall_o = pending[id_reg1_raddr_i]
                     | pending[id_reg2_raddr_i]
                     | pending[id_rd_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         pending    <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         pending    <= pending_nxt;
      end
   end

   // x0 writes complete the handshake but never assert the enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_reg_we_o    <= 1'b0;
         wb_reg_waddr_o <= '0;
         wb_op_c_o      <= '0;
      end else begin
         wb_reg_we_o <= w_any && (w_addr != 5'd0);
         if (w_any) begin
            wb_reg_waddr_o <= w_addr;
            wb_op_c_o      <= w_data;
         end
      end
   end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed scenarios plus random traffic
// checked against a behavioural scoreboard/arbiter model.
module tb_regs_wb_arbiter;

   localparam int SMAX = 4;

   logic        clk;
   logic        rst_n;
   logic        p_valid;
   logic [4:0]  p_waddr;
   logic [31:0] p_wdata;
   logic        p_ready;
   logic        l_valid;
   logic [4:0]  l_waddr;
   logic [31:0] l_wdata;
   logic        l_ready;
   logic        l_issue;
   logic [4:0]  l_issue_rd;
   logic [4:0]  r1;
   logic [4:0]  r2;
   logic [4:0]  rd;
   logic        stall;
   logic [31:0] op_c;
   logic [4:0]  waddr;
   logic        we;

   int nvec;
   int nerr;

   // reference model state
   bit [31:0] m_pend;
   int        m_starve;
   bit        m_we;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   bit        g_p;
   bit        g_l;

   regs_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .p_valid_i       (p_valid),
      .p_waddr_i       (p_waddr),
      .p_wdata_i       (p_wdata),
      .p_ready_o       (p_ready),
      .l_valid_i       (l_valid),
      .l_waddr_i       (l_waddr),
      .l_wdata_i       (l_wdata),
      .l_ready_o       (l_ready),
      .l_issue_i       (l_issue),
      .l_issue_rd_i    (l_issue_rd),
      .id_reg1_raddr_i (r1),
      .id_reg2_raddr_i (r2),
      .id_rd_i         (rd),
      .id_stall_o      (stall),
      .wb_op_c_o       (op_c),
      .wb_reg_waddr_o  (waddr),
      .wb_reg_we_o     (we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs,
                        logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pend   = '0;
      m_starve = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic idle_inputs();
      p_valid    = 1'b0;
      p_waddr    = '0;
      p_wdata    = '0;
      l_valid    = 1'b0;
      l_waddr    = '0;
      l_wdata    = '0;
      l_issue    = 1'b0;
      l_issue_rd = '0;
      r1         = '0;
      r2         = '0;
      rd         = '0;
   endtask

   // One cycle: starts at negedge with inputs set, ends at next negedge.
   task automatic step();
      bit       ep;
      bit       el;
      bit       es;
      bit [4:0] a;
      #1;
      el = l_valid && (!p_valid || m_starve == SMAX);
      ep = p_valid && !el;
      es = m_pend[r1] | m_pend[r2] | m_pend[rd];
      g_p = ep;
      g_l = el;
      check("p_ready", p_ready, ep);
      check("l_ready", l_ready, el);
      check("id_stall", stall, es);
      @(posedge clk);
      if (ep || el) begin
         a    = ep ? p_waddr : l_waddr;
         m_we = (a != 0);
         if (a != 0) begin
            m_addr = a;
            m_data = ep ? p_wdata : l_wdata;
         end
      end else begin
         m_we = 1'b0;
      end
      if (el) m_pend[l_waddr] = 1'b0;
      if (l_issue && l_issue_rd != 0) m_pend[l_issue_rd] = 1'b1;
      if (l_valid && !el)
         m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else
         m_starve = 0;
      #1;
      check("we", we, m_we);
      if (m_we) begin
         check("waddr", waddr, m_addr);
         check("wdata", op_c, m_data);
      end
      @(negedge clk);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      idle_inputs();
      m_reset();
      rst_n = 1'b0;

      // 1: reset state and a plain P write
      p_valid = 1'b1;
      l_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_we", we, 0);
      check("rst_stall", stall, 0);
      check("rst_p_ready", p_ready, 0);
      check("rst_l_ready", l_ready, 0);
      idle_inputs();
      rst_n = 1'b1;
      p_valid = 1'b1;
      p_waddr = 5'd5;
      p_wdata = 32'hDEADBEEF;
      step();
      check("t1_waddr", waddr, 5);
      check("t1_wdata", op_c, 32'hDEADBEEF);
      idle_inputs();
      step();

      // 2: starvation limit
      p_valid = 1'b1;
      p_waddr = 5'd10;
      l_valid = 1'b1;
      l_waddr = 5'd11;
      l_wdata = 32'h1111_0000;
      for (int i = 0; i < 6; i++) begin
         p_wdata = 32'hA000_0000 + i;
         step();
         check("t2_lwin", g_l, (i == SMAX));
         if (g_l) l_valid = 1'b0;
      end
      idle_inputs();

      // 3: RAW stall until L writes rd 7
      l_issue    = 1'b1;
      l_issue_rd = 5'd7;
      step();
      l_issue = 1'b0;
      r1      = 5'd7;
      step();
      check("t3_stall_pend", stall, 1);
      l_valid = 1'b1;
      l_waddr = 5'd7;
      l_wdata = 32'h7777_7777;
      step();
      check("t3_stall_gnt", g_l, 1);
      l_valid = 1'b0;
      step();
      idle_inputs();

      // 4: issue and L write to same rd, set wins
      l_issue    = 1'b1;
      l_issue_rd = 5'd9;
      l_valid    = 1'b1;
      l_waddr    = 5'd9;
      l_wdata    = 32'h9999_0009;
      step();
      idle_inputs();
      r2 = 5'd9;
      #1;
      check("t4_stall", stall, 1);
      step();
      l_valid = 1'b1;
      l_waddr = 5'd9;
      step();
      idle_inputs();

      // 5: x0 writes and issues
      p_valid = 1'b1;
      p_waddr = 5'd0;
      p_wdata = 32'h1234;
      step();
      p_valid    = 1'b0;
      l_issue    = 1'b1;
      l_issue_rd = 5'd0;
      step();
      l_issue = 1'b0;
      r1 = 5'd0;
      r2 = 5'd0;
      rd = 5'd0;
      step();
      idle_inputs();

      // 6: reset in the middle of traffic
      p_valid    = 1'b1;
      p_waddr    = 5'd13;
      p_wdata    = 32'h1313_1313;
      l_valid    = 1'b1;
      l_waddr    = 5'd12;
      l_wdata    = 32'h1212_1212;
      l_issue    = 1'b1;
      l_issue_rd = 5'd3;
      step();
      l_issue_rd = 5'd4;
      step();
      l_issue = 1'b0;
      r1 = 5'd3;
      r2 = 5'd4;
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_we", we, 0);
      check("t6_p_ready", p_ready, 0);
      check("t6_l_ready", l_ready, 0);
      check("t6_stall", stall, 0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      r1 = 5'd3;
      r2 = 5'd4;
      step();

      // random traffic, losers hold their request
      for (int n = 0; n < 400; n++) begin
         if (!(p_valid && !g_p)) begin
            p_valid = ($urandom_range(0, 2) != 0);
            p_waddr = 5'($urandom_range(0, 7));
            p_wdata = $urandom;
         end
         if (!(l_valid && !g_l)) begin
            l_valid = ($urandom_range(0, 2) != 0);
            l_waddr = 5'($urandom_range(0, 7));
            l_wdata = $urandom;
         end
         l_issue    = ($urandom_range(0, 3) == 0);
         l_issue_rd = 5'($urandom_range(0, 7));
         r1 = 5'($urandom_range(0, 7));
         r2 = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 7));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
